// File: rtl/if_id_pipe_reg_pkg.sv
// Shared definitions for the fetch-to-decode pipeline register:
// the default bubble instruction and the handshake state encoding.
package if_id_pipe_reg_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/if_id_pipe_reg_skid_slot.sv
// One data+valid holding slot. Clear drops the valid bit and forces the bubble
// instruction but leaves the PC alone; clear wins over load.
module pipe_skid_slot #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] pc_d,
    input  logic [DATA_W-1:0] instr_d,
    output logic              valid,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            pc    <= '0;
            instr <= NOP_INSTR;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
        end else if (load) begin
            valid <= 1'b1;
            pc    <= pc_d;
            instr <= instr_d;
        end
    end

endmodule

// File: rtl/if_id_pipe_reg.sv
// Fetch-to-decode pipeline register with valid/ready handshake, flush,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_DEFAULT),
    parameter bit                SKID_EN   = 1'b1,
    parameter int                CNT_W     = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PCAddResult,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Flush,
    output logic [ADDR_W-1:0] PCAddResultOut,
    output logic [DATA_W-1:0] InstructionOut,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [CNT_W-1:0]  StallCount
);

    logic              accept, out_xfer;
    logic              m_load, m_clear, m_valid;
    logic [ADDR_W-1:0] m_pc_d;
    logic [DATA_W-1:0] m_instr_d;
    logic              s_valid;
    logic [ADDR_W-1:0] s_pc;
    logic [DATA_W-1:0] s_instr;

    assign accept   = InValid & InReady;
    assign out_xfer = m_valid & OutReady;
    assign OutValid = m_valid;

    // M refills from the skid slot whenever it holds something; S is only
    // occupied in SKID, where InReady is low and no new input can arrive.
    assign m_pc_d    = s_valid ? s_pc    : PCAddResult;
    assign m_instr_d = s_valid ? s_instr : Instruction;

    pipe_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk     (Clk),
        .reset   (Reset),
        .load    (m_load),
        .clear   (m_clear),
        .pc_d    (m_pc_d),
        .instr_d (m_instr_d),
        .valid   (m_valid),
        .pc      (PCAddResultOut),
        .instr   (InstructionOut)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_state_e state, state_nx;
            logic        in_ready_q;
            logic        s_load, s_clear;

            pipe_skid_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
                .clk     (Clk),
                .reset   (Reset),
                .load    (s_load),
                .clear   (s_clear),
                .pc_d    (PCAddResult),
                .instr_d (Instruction),
                .valid   (s_valid),
                .pc      (s_pc),
                .instr   (s_instr)
            );

            assign InReady = in_ready_q;

            always_comb begin
                state_nx = state;
                m_load   = 1'b0;
                m_clear  = 1'b0;
                s_load   = 1'b0;
                s_clear  = 1'b0;
                if (Flush) begin
                    state_nx = EMPTY;
                    m_clear  = 1'b1;
                    s_clear  = 1'b1;
                end else begin
                    case (state)
                        EMPTY: begin
                            if (accept) begin
                                state_nx = FULL;
                                m_load   = 1'b1;
                            end
                        end
                        FULL: begin
                            if (accept && out_xfer) begin
                                m_load = 1'b1;
                            end else if (accept) begin
                                state_nx = SKID;
                                s_load   = 1'b1;
                            end else if (out_xfer) begin
                                state_nx = EMPTY;
                                m_clear  = 1'b1;
                            end
                        end
                        SKID: begin
                            if (out_xfer) begin
                                state_nx = FULL;
                                m_load   = 1'b1;
                                s_clear  = 1'b1;
                            end
                        end
                        default: state_nx = EMPTY;
                    endcase
                end
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end else begin
                    state      <= state_nx;
                    in_ready_q <= (state_nx != SKID);
                end
            end
        end else begin : g_single
            assign s_valid = 1'b0;
            assign s_pc    = '0;
            assign s_instr = NOP_INSTR;
            assign InReady = !m_valid || OutReady;
            assign m_load  = accept && !Flush;
            assign m_clear = Flush || (out_xfer && !accept);
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset)
            StallCount <= '0;
        else if (m_valid && !OutReady && (StallCount != {CNT_W{1'b1}}))
            StallCount <= StallCount + 1'b1;
    end

endmodule

// File: doc/if_id_pipe_reg.md
Name: if_id_pipe_reg

Overview:
Parametrised fetch-to-decode pipeline register. It adds valid/ready handshaking, flush, an optional 2-entry skid buffer and a stall-cycle counter.
- Sits between the fetch stage (PC+4 adder, instruction memory) and the decode stage.
- Lets decode back-pressure fetch without losing instructions.
- Lets branch resolution squash in-flight instructions.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 32, PC+4 address width
NOP_INSTR, 32'h0000_0000, value driven on InstructionOut when no valid entry (width DATA_W)
SKID_EN, 1, 1 = 2-entry skid buffer with registered InReady; 0 = single register with combinational InReady
CNT_W, 16, width of the stall counter

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high reset
PCAddResult  in  ADDR_W  PC+4 from fetch
Instruction  in  DATA_W  instruction from fetch
InValid  in  1  fetch presents a valid instruction
InReady  out  1  register can accept this cycle
Flush  in  1  squash all held entries (branch/jump taken)
PCAddResultOut  out  ADDR_W  PC+4 to decode
InstructionOut  out  DATA_W  instruction to decode
OutValid  out  1  outputs hold a valid entry
OutReady  in  1  decode accepts this cycle
StallCount  out  CNT_W  saturating count of cycles with OutValid=1 and OutReady=0

Behaviour:
Clocking and reset:
- One clock; reset is synchronous and active-high.
- Reset (highest priority) takes effect on the Clk edge where Reset=1:
  - OutValid=0, PCAddResultOut=0, InstructionOut=NOP_INSTR, StallCount=0.
  - State=EMPTY; InReady=1 from the first cycle after the reset edge.
- A reset mid-transfer discards all held data.

Handshake:
- Input transfer when InValid and InReady on a Clk edge.
- Output transfer when OutValid and OutReady on a Clk edge.
- Latency: accepted data appears on the outputs one cycle after acceptance when the main register is empty. Outputs are always registered.

SKID_EN=1 state machine (main register M, skid register S):
- EMPTY (InReady=1, OutValid=0):
  - accept -> FULL, data into M.
- FULL (InReady=1, OutValid=1):
  - accept and output transfer -> FULL, M gets new data.
  - accept, no output transfer -> SKID, new data into S.
  - output transfer only -> EMPTY.
  - neither -> hold.
- SKID (InReady=0, OutValid=1):
  - output transfer -> FULL, M<=S.
  - otherwise hold. An input presented while InReady=0 is ignored; fetch must hold it.
- InReady is a register output, equal to (next state != SKID).

SKID_EN=0:
- Single register M.
- InReady = !OutValid || OutReady (combinational).
- M loads on every input transfer; OutValid clears on an output transfer with no input transfer.

Flush:
- Flush=1 on an edge (Reset=0): state=EMPTY, OutValid=0, InstructionOut=NOP_INSTR, PCAddResultOut unchanged, S invalidated.
- Any input accepted on the same edge is discarded.
- An output transfer on the same edge still counts as completed for decode.

Output rules:
- When OutValid=0, InstructionOut=NOP_INSTR so a stalled decode sees a bubble.
- M/S data only change on load; no X propagation.

StallCount:
- Increments by 1 each edge with OutValid=1, OutReady=0, Reset=0.
- Saturates at 2^CNT_W-1; no wrap.
- Unaffected by Flush; cleared only by Reset.

Simultaneous events: priority is Reset > Flush > normal handshake. A fetch input and a decode consume on the same edge in FULL sustain 1 instruction/cycle throughput.

Decomposition:
Shared pipeline package holds:
- NOP_INSTR default (32'h0000_0000).
- State encoding localparams: EMPTY=2'd0, FULL=2'd1, SKID=2'd2.

One natural sub-module, pipe_skid_slot: a data+valid register with load/clear, instantiated for M and S. FSM and counter stay in the top.

Test Plan:
1. Reset: hold Reset 2 cycles with InValid=1, Instruction=32'h2002_0005 -> OutValid=0, InstructionOut=32'h0, StallCount=0, InReady=1 after release.
2. Streaming: OutReady=1, feed PC+4=4,8,12 with instructions A,B,C on consecutive cycles -> outputs appear 1 cycle later, in order, one per cycle, InReady stays 1.
3. Back-pressure (SKID_EN=1): fill with A, drop OutReady, present B -> state SKID, InReady=0, OutValid=1 with A. Raise OutReady -> A then B delivered, no loss, no duplication. StallCount counts exactly the low-OutReady cycles.
4. Flush: in SKID holding A,B, assert Flush with InValid=1 carrying C -> next cycle OutValid=0, InstructionOut=NOP, InReady=1, C never appears.
5. Saturation: CNT_W=4, hold OutValid=1, OutReady=0 for 20 cycles -> StallCount stops at 15.
6. SKID_EN=0 build: OutReady=0 with a held entry -> InReady=0 the same cycle. OutReady=1 with InValid=1 -> new entry replaces old on that edge.
